// File: rtl/priority_encoder_8to3_pkg.sv
// Shared definitions for the 8-to-3 handshaked priority encoder.
package priority_encoder_8to3_pkg;

  localparam int N_REQ  = 8;
  localparam int W_CODE = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // 3-to-8 decode of a code; the encoder output is its inverse.
  function automatic logic [N_REQ-1:0] onehot8(input logic [W_CODE-1:0] idx);
    logic [N_REQ-1:0] v;
    v = 8'b0000_0001 << idx;
    return v;
  endfunction

endpackage

// File: rtl/priority_encoder_8to3_pick8.sv
// Combinational priority pick over an 8-bit vector.
// i_low_first = 0 selects the highest set index, 1 selects the lowest.
module priority_pick8
  import priority_encoder_8to3_pkg::*;
(
  input  logic [N_REQ-1:0]  i_vec,
  input  logic              i_low_first,
  output logic [W_CODE-1:0] o_idx,
  output logic              o_any
);

  logic [N_REQ-1:0]  w_scan;
  logic [W_CODE-1:0] w_top;

  // Bit-reverse the vector for low-first so one highest-bit search serves both orders.
  always_comb begin
    w_scan = i_vec;
    if (i_low_first) begin
      for (int i = 0; i < N_REQ; i++) begin
        w_scan[i] = i_vec[N_REQ-1-i];
      end
    end else begin
      w_scan = i_vec;
    end
  end

  // Position of the highest set bit in the scan vector.
  always_comb begin
    casez (w_scan)
      8'b1???_????: w_top = 3'd7;
      8'b01??_????: w_top = 3'd6;
      8'b001?_????: w_top = 3'd5;
      8'b0001_????: w_top = 3'd4;
      8'b0000_1???: w_top = 3'd3;
      8'b0000_01??: w_top = 3'd2;
      8'b0000_001?: w_top = 3'd1;
      8'b0000_0001: w_top = 3'd0;
      default:      w_top = 3'd0;
    endcase
  end

  // Map the scan position back to an original index and flag any request.
  always_comb begin
    o_any = |i_vec;
    if (i_low_first) begin
      o_idx = 3'd7 - w_top;
    end else begin
      o_idx = w_top;
    end
  end

endmodule

// File: rtl/priority_encoder_8to3.sv
// 8-to-3 priority encoder with sticky pending bits and a valid/ready
// handshake. One index is offered at a time; an offer is never preempted.
module priority_encoder_8to3
  import priority_encoder_8to3_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
)
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_REQ-1:0]  i_req,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [W_CODE-1:0] o_code,
  output logic [N_REQ-1:0]  o_pending,
  output logic              o_lost
);

  state_t            r_state;
  logic [W_CODE-1:0] r_code;
  logic [N_REQ-1:0]  r_pending;
  logic              r_lost;

  logic              w_handshake;
  logic [N_REQ-1:0]  w_served;
  logic [N_REQ-1:0]  w_keep;
  logic [N_REQ-1:0]  w_pending_nxt;
  logic              w_lost_hit;
  logic [W_CODE-1:0] w_idx;
  logic              w_any;

  // Handshake, served mask and next pending vector (set wins over clear).
  always_comb begin
    w_handshake   = (r_state == OFFER) && i_ready;
    w_served      = w_handshake ? onehot8(r_code) : 8'h00;
    w_keep        = r_pending & ~w_served;
    w_pending_nxt = w_keep | i_req;
    w_lost_hit    = |(i_req & w_keep);
  end

  // In IDLE nothing is served so w_keep equals pending; after a handshake it
  // is the remaining vector. One picker therefore covers both loads.
  priority_pick8 u_pick (
    .i_vec       (w_keep),
    .i_low_first (LOW_FIRST),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  // Pending vector and sticky lost flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 8'h00;
      r_lost    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_lost    <= r_lost | w_lost_hit;
    end
  end

  // Offer FSM: load a code from IDLE, hold while stalled, chain after a handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_code  <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_code  <= w_idx;
            r_state <= OFFER;
          end else begin
            r_state <= IDLE;
          end
        end
        OFFER: begin
          if (i_ready) begin
            if (w_any) begin
              r_code  <= w_idx;
              r_state <= OFFER;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_state <= OFFER;
          end
        end
        default: begin
          r_state <= IDLE;
          r_code  <= 3'd0;
        end
      endcase
    end
  end

  assign o_valid   = (r_state == OFFER);
  assign o_code    = r_code;
  assign o_pending = r_pending;
  assign o_lost    = r_lost;

endmodule
